// File: rtl/handshake_rr_arbiter.sv
// handshake_rr_arbiter: round-robin arbiter that merges N_REQ ready/valid requesters
// onto one registered ready/valid output slot (one-cycle latency, 1 beat/cycle).
// Optional macro HANDSHAKE_RR_ARBITER_ASSERT_EN embeds protocol/fairness assertions.
module handshake_rr_arbiter #(
    parameter int unsigned N_REQ = 3,
    parameter int unsigned WIDTH = 4,
    localparam int unsigned IDX_W = $clog2(N_REQ)
) (
    input  logic                   CLK,
    input  logic                   ASYNCRESETN,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    input  logic                   out_ready,
    output logic [IDX_W-1:0]       out_grant,
    output logic                   busy
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [IDX_W-1:0] win;
    logic             found;
    logic             can_accept;
    logic             xfer;

    // Round-robin search starting just after the last granted index.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx = (int'(ptr_q) + k) % N_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = IDX_W'(idx);
            end
        end
    end

    // Handshake towards requesters; gated by reset so nothing is accepted while held.
    always_comb begin
        can_accept = (state_q == StEmpty) || out_ready;
        xfer       = found && can_accept && ASYNCRESETN;
        req_ready  = xfer ? (N_REQ'(1) << win) : '0;
    end

    // Slot next-state: fill on transfer, empty on drain without fill, hold otherwise.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        data_d  = data_q;
        if (xfer) begin
            state_d = StFull;
            ptr_d   = win;
            grant_d = win;
            data_d  = req_data[win*WIDTH +: WIDTH];
        end else if (state_q == StFull && out_ready) begin
            state_d = StEmpty;
        end
    end

    // State registers; requester 0 has first priority after reset.
    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q <= StEmpty;
            ptr_q   <= IDX_W'(N_REQ - 1);
            grant_q <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            data_q  <= data_d;
        end
    end

    // Output drive.
    always_comb begin
        out_valid = (state_q == StFull);
        out_data  = data_q;
        out_grant = grant_q;
        busy      = out_valid || (|req_valid);
    end

`ifdef HANDSHAKE_RR_ARBITER_ASSERT_EN
    // Transfers granted to others while each requester keeps valid asserted.
    logic [N_REQ-1:0][IDX_W:0] wait_q;

    for (genvar i = 0; i < N_REQ; i++) begin : g_fair
        // Count competing transfers; clear on own grant or withdrawal.
        always_ff @(posedge CLK or negedge ASYNCRESETN) begin
            if (!ASYNCRESETN) begin
                wait_q[i] <= '0;
            end else if (!req_valid[i] || (xfer && win == IDX_W'(i))) begin
                wait_q[i] <= '0;
            end else if (xfer) begin
                wait_q[i] <= wait_q[i] + 1'b1;
            end
        end

        a_fair: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
            32'(wait_q[i]) < N_REQ);
    end

    a_onehot: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        $onehot0(req_ready));

    a_hold: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        out_valid && !out_ready |=>
            $stable(out_valid) && $stable(out_data) && $stable(out_grant));

    a_grant_rng: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
        32'(out_grant) < N_REQ);
`else
`endif

endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
- Round-robin arbiter sharing one registered ready/valid output channel between N_REQ ready/valid requesters.
- Each requester carries a WIDTH-bit payload.
- Sits in front of the shared RTL datapath port (handshake in, 4-bit operand) and replaces ad-hoc muxing of the handshake_arr_* requesters.
- Guarantees fair, lossless, in-order-per-requester transfer with one-cycle latency.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- WIDTH, 4, payload width in bits.
- IDX_W, $clog2(N_REQ), width of grant index (derived, not overridden).

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- ASYNCRESETN  input  1  asynchronous active-low reset.
- req_valid  input  N_REQ  per-requester valid.
- req_data  input  N_REQ*WIDTH  packed payloads; requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  output  N_REQ  per-requester ready; at most one bit set (one-hot or zero).
- out_valid  output  1  shared-channel valid (registered).
- out_data  output  WIDTH  shared-channel payload (registered).
- out_ready  input  1  shared-channel ready from datapath.
- out_grant  output  IDX_W  index of requester whose beat is in out_data (registered).
- busy  output  1  high while out_valid=1 or any req_valid=1.

Behaviour:
- States: EMPTY (out_valid=0) and FULL (out_valid=1). The output register is a single slot.
- Slot can accept in cycle t iff state=EMPTY, or state=FULL with out_ready=1 (drain and fill in the same cycle).
- Arbitration is combinational:
  - Search order is ptr+1, ptr+2, ..., wrapping from N_REQ-1 to 0 and ending at ptr.
  - The first index with req_valid=1 is the winner g.
  - req_ready[g]=1 only if the slot can accept; all other req_ready bits are 0.
  - No valid requests: req_ready=0.
- Transfer: req_valid[g] & req_ready[g] at edge t loads req_data[g] into out_data and g into out_grant. out_valid=1 from t+1. Latency is exactly 1 cycle.
- Pointer: ptr<=g only on a transfer. With no transfer, ptr holds.
- Fairness: a requester holding valid is granted within N_REQ transfers.
- Hold: while FULL and out_ready=0, out_valid, out_data and out_grant are stable. All req_ready=0.
- Drain without fill: out_valid & out_ready with no transfer moves the block to EMPTY. out_data and out_grant hold their last values (don't-care).
- Drain with fill: the new beat replaces the old one and out_valid stays 1. Sustained throughput is 1 beat/cycle.
- Requester withdrawing valid before a transfer is legal at this block. Arbitration re-evaluates each cycle, with no lock before handshake.
- Reset values (ASYNCRESETN=0, asynchronous):
  - out_valid=0, out_data=0, out_grant=0.
  - ptr=N_REQ-1, so requester 0 has first priority.
  - req_ready=0 while reset is asserted.
- Reset mid-operation: a beat held in the slot is discarded, not replayed. Deassertion is synchronized by the system. The first grant is possible in the first cycle after deassertion.
- Combinational path out_ready -> req_ready exists by design. No path from req_valid to out_valid.

Optional Feature:
- Macro: HANDSHAKE_RR_ARBITER_ASSERT_EN.
- Defined: embedded concurrent assertions on posedge CLK, disabled while ASYNCRESETN=0. They check:
  - req_ready is $onehot0.
  - out_valid && !out_ready implies out_valid, out_data and out_grant are $stable next cycle.
  - out_grant < N_REQ.
  - Any req_valid held continuously is granted within N_REQ transfers.
- Undefined: no assertion code is emitted. Functional RTL is identical.

Test Plan:
1. Reset, then req_valid=3'b001 with data0=4'hA, out_ready=1 -> req_ready=3'b001 in cycle 0. Cycle 1: out_valid=1, out_data=4'hA, out_grant=0.
2. All three valid every cycle, data i=4'h1+i, out_ready=1 -> grants 0,1,2,0,1,2. out_data is 1,2,3,1,2,3 on consecutive cycles with no bubbles.
3. FULL with out_grant=1, out_data=4'h5, out_ready=0 for 4 cycles, all requests valid -> req_ready=0 and outputs stable. First cycle out_ready=1: requester 2 is granted and out_data updates next cycle.
4. Only requester 2 valid for 3 beats, then requesters 0 and 2 valid -> requester 0 is granted next (ptr=2 wraps to 0).
5. ASYNCRESETN pulsed low mid-cycle while FULL, unsynchronized to CLK -> out_valid=0 and out_data=0 immediately. Requester 0 gets first grant after release.
6. Requester 1 raises then drops valid while the slot is FULL and stalled -> no transfer recorded, ptr unchanged. Assertions (with HANDSHAKE_RR_ARBITER_ASSERT_EN) do not fire.
